// File: rtl/bpt_pkg.sv
// Shared types and defaults for the branch prediction table update scheduler.
package bpt_pkg;

    localparam int BPT_PC_W  = 32;
    localparam int BPT_IDX_W = 11;

    // Counter value a swept entry is forced to (strongly not taken).
    localparam logic [1:0] BPT_CLEAR_STATE = 2'b00;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWEEP
    } bpt_ctrl_state_t;

    typedef struct packed {
        logic [BPT_PC_W-1:0] pc;
        logic                taken;
    } bpt_upd_t;

endpackage

// File: rtl/bpt_upd_fifo.sv
// Update FIFO: up to two pushes and one pop per cycle; push slot 0 is the older entry.
module bpt_upd_fifo
    import bpt_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [1:0]    push,
    input  bpt_upd_t      push_data0,
    input  bpt_upd_t      push_data1,
    input  logic          pop,
    output bpt_upd_t      head,
    output logic          empty,
    output logic [CW-1:0] count
);

    bpt_upd_t        mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   slot1;
    logic            pop_ok;

    // The second pushed entry lands behind the first only if the first was written.
    assign slot1  = wr_ptr_reg + AW'(push[0]);
    assign pop_ok = pop & (count_reg != '0);

    always_ff @(posedge CLK) begin
        if (push[0]) mem_reg[wr_ptr_reg] <= push_data0;
        if (push[1]) mem_reg[slot1]      <= push_data1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push[0]) + AW'(push[1]);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop_ok);
            count_reg  <= count_reg + CW'(push[0]) + CW'(push[1]) - CW'(pop_ok);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/bpt_update_ctrl.sv
// Scheduler for the branch prediction table update port: buffers resolutions, drains, and sweeps.
// Optional stats counters are enabled by defining BPT_UPDATE_STATS_EN.
module bpt_update_ctrl
    import bpt_pkg::*;
#(
    parameter int PC_W  = BPT_PC_W,
    parameter int IDX_W = BPT_IDX_W,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [1:0]      res_valid,
    input  logic [2*PC_W-1:0] res_pc,
    input  logic [1:0]      res_taken,
    output logic [1:0]      res_ready,
    input  logic            clear_req,
    output logic            busy,
    output logic            sweep_done,
    output logic            bpt_enable,
    output logic [PC_W-1:0] bpt_pc,
    output logic            bpt_taken,
    output logic            bpt_clear,
    input  logic            bpt_pred_correct
`ifdef BPT_UPDATE_STATS_EN
    ,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    bpt_ctrl_state_t  state_reg, state_next;
    logic             rr_reg, rr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    logic [1:0]       push;
    logic             pop;
    bpt_upd_t         push_data0, push_data1, head;
    logic             empty;
    logic [CW-1:0]    count;

    always_comb begin
        push_data0.pc    = BPT_PC_W'(res_pc[PC_W-1:0]);
        push_data0.taken = res_taken[0];
        push_data1.pc    = BPT_PC_W'(res_pc[2*PC_W-1:PC_W]);
        push_data1.taken = res_taken[1];
    end

    assign push = res_valid & res_ready;

    bpt_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK        (CLK),
        .nRST       (nRST),
        .push       (push),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .count      (count)
    );

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        idx_next   = idx_reg;
        res_ready  = 2'b00;
        pop        = 1'b0;
        bpt_enable = 1'b0;
        bpt_clear  = 1'b0;
        bpt_taken  = 1'b0;
        bpt_pc     = '0;
        sweep_done = 1'b0;

        case (state_reg)
            RUN: begin
                // Ready uses only the registered count, so a same-cycle pop never opens a slot.
                if (count <= CW'(DEPTH - 2)) begin
                    res_ready = 2'b11;
                end else if (count == CW'(DEPTH - 1)) begin
                    if (res_valid == 2'b11) begin
                        res_ready = rr_reg ? 2'b10 : 2'b01;
                        rr_next   = ~rr_reg;
                    end else if (res_valid[1]) begin
                        res_ready = 2'b10;
                    end else begin
                        res_ready = 2'b01;
                    end
                end
                pop = ~empty;
                if (clear_req) state_next = DRAIN;
            end
            DRAIN: begin
                pop = ~empty;
                if (empty || count == CW'(1)) state_next = SWEEP;
            end
            SWEEP: begin
                bpt_enable = 1'b1;
                bpt_clear  = 1'b1;
                bpt_pc     = PC_W'({idx_reg, 2'b00});
                idx_next   = idx_reg + 1'b1;
                if (&idx_reg) begin
                    sweep_done = 1'b1;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        if (state_reg != SWEEP && !empty) begin
            bpt_enable = 1'b1;
            bpt_pc     = PC_W'(head.pc);
            bpt_taken  = head.taken;
        end
    end

    assign busy = (state_reg != RUN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= RUN;
            rr_reg    <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            idx_reg   <= idx_next;
        end
    end

`ifdef BPT_UPDATE_STATS_EN
    logic [31:0] stat_updates_reg;
    logic [31:0] stat_mispredicts_reg;
    logic        drain_wr;

    assign drain_wr = bpt_enable & ~bpt_clear;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (drain_wr) begin
            if (stat_updates_reg != '1)
                stat_updates_reg <= stat_updates_reg + 32'd1;
            if (!bpt_pred_correct && stat_mispredicts_reg != '1)
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`else
    logic unused_pred_correct;
    assign unused_pred_correct = bpt_pred_correct;
`endif

endmodule

// File: tb/tb_bpt_update_ctrl.sv
// Directed bench for bpt_update_ctrl: accept/drain order, round-robin, clear sweep, reset, stats.
module tb_bpt_update_ctrl;

    localparam int PC_W  = 32;
    localparam int IDX_W = 11;
    localparam int DEPTH = 4;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [1:0]      res_valid;
    logic [2*PC_W-1:0] res_pc;
    logic [1:0]      res_taken;
    logic [1:0]      res_ready;
    logic            clear_req;
    logic            busy;
    logic            sweep_done;
    logic            bpt_enable;
    logic [PC_W-1:0] bpt_pc;
    logic            bpt_taken;
    logic            bpt_clear;
    logic            bpt_pred_correct;
`ifdef BPT_UPDATE_STATS_EN
    logic [31:0]     stat_updates;
    logic [31:0]     stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bpt_update_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_ready        (res_ready),
        .clear_req        (clear_req),
        .busy             (busy),
        .sweep_done       (sweep_done),
        .bpt_enable       (bpt_enable),
        .bpt_pc           (bpt_pc),
        .bpt_taken        (bpt_taken),
        .bpt_clear        (bpt_clear),
        .bpt_pred_correct (bpt_pred_correct)
`ifdef BPT_UPDATE_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and step just past the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [1:0]  exp_ready [6] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_wr    [8] = '{32'h1000, 32'h2000, 32'h1010, 32'h2010,
                                   32'h1020, 32'h2020, 32'h1030, 32'h2030};
    int          a_i, b_i, done_cnt;
    logic        seen;

    initial begin
        nRST             = 1'b0;
        res_valid        = 2'b00;
        res_pc           = '0;
        res_taken        = 2'b00;
        clear_req        = 1'b0;
        bpt_pred_correct = 1'b1;
        #1;
        check("rst_ready",  64'(res_ready),  64'h3);
        check("rst_enable", 64'(bpt_enable), 64'h0);
        check("rst_pc",     64'(bpt_pc),     64'h0);
        check("rst_busy",   64'(busy),       64'h0);
        check("rst_clear",  64'(bpt_clear),  64'h0);
        check("rst_done",   64'(sweep_done), 64'h0);
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        // Single event, written one cycle later
        tick();
        res_valid = 2'b01; res_pc[31:0] = 32'h0000_1004; res_taken = 2'b01;
        #1;
        check("single_ready", 64'(res_ready), 64'h3);
        tick();
        res_valid = 2'b00;
        #1;
        $display("write pc=0x%0h taken=%0d en=%0d", bpt_pc, bpt_taken, bpt_enable);
        check("single_en",    64'(bpt_enable), 64'h1);
        check("single_pc",    64'(bpt_pc),     64'h1004);
        check("single_taken", 64'(bpt_taken),  64'h1);
        check("single_clr",   64'(bpt_clear),  64'h0);
        tick();
        #1;
        check("single_empty", 64'(bpt_enable), 64'h0);

        // Both requesters streaming: round-robin once one slot remains
        a_i = 0; b_i = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            res_valid = 2'b11;
            res_pc    = {32'h2000 + 32'(16 * b_i), 32'h1000 + 32'(16 * a_i)};
            res_taken = 2'b01;
            #1;
            $display("cycle %0d ready=%b write_en=%0d pc=0x%0h", c, res_ready, bpt_enable, bpt_pc);
            check($sformatf("rr_ready%0d", c), 64'(res_ready), 64'(exp_ready[c]));
            if (c >= 1) begin
                check($sformatf("rr_pc%0d", c),    64'(bpt_pc),    64'(exp_wr[c-1]));
                check($sformatf("rr_taken%0d", c), 64'(bpt_taken), 64'(exp_wr[c-1][12]));
            end
            a_i += int'(exp_ready[c][0]);
            b_i += int'(exp_ready[c][1]);
        end
        for (int c = 5; c < 8; c++) begin
            tick();
            res_valid = 2'b00;
            #1;
            $display("drain write pc=0x%0h", bpt_pc);
            check($sformatf("drain_pc%0d", c), 64'(bpt_pc),     64'(exp_wr[c]));
            check($sformatf("drain_en%0d", c), 64'(bpt_enable), 64'h1);
        end
        tick();
        #1;
        check("drain_done", 64'(bpt_enable), 64'h0);

        // Fill, request clear, drain, then full sweep with a stray clear_req at index 100
        tick();
        res_valid = 2'b11; res_pc = {32'h3004, 32'h3000}; res_taken = 2'b10;
        #1;
        check("fill_ready0", 64'(res_ready), 64'h3);
        tick();
        res_pc = {32'h300C, 32'h3008}; clear_req = 1'b1;
        #1;
        check("fill_ready1", 64'(res_ready), 64'h3);
        check("fill_busy",   64'(busy),      64'h0);
        check("fill_pc",     64'(bpt_pc),    64'h3000);
        for (int d = 1; d <= 3; d++) begin
            tick();
            clear_req = 1'b0; res_pc = {32'h4004, 32'h4000};
            #1;
            $display("clear-drain write pc=0x%0h", bpt_pc);
            check($sformatf("cd_busy%0d", d),  64'(busy),      64'h1);
            check($sformatf("cd_ready%0d", d), 64'(res_ready), 64'h0);
            check($sformatf("cd_pc%0d", d),    64'(bpt_pc),    64'(32'h3000 + 32'(4 * d)));
            check($sformatf("cd_clr%0d", d),   64'(bpt_clear), 64'h0);
        end
        done_cnt = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            res_valid = 2'b00;
            clear_req = (i == 100);
            #1;
            if (sweep_done) done_cnt++;
            check("sweep_pc",    64'(bpt_pc),                  64'(4 * i));
            check("sweep_flags", 64'({bpt_enable, bpt_clear, bpt_taken}), 64'h6);
            check("sweep_done",  64'(sweep_done),              64'(i == 2047));
        end
        $display("sweep finished, sweep_done pulses=%0d", done_cnt);
        check("sweep_done_cnt", 64'(done_cnt), 64'h1);
        tick();
        clear_req = 1'b0;
        #1;
        check("post_sweep_ready", 64'(res_ready),  64'h3);
        check("post_sweep_busy",  64'(busy),       64'h0);
        check("post_sweep_en",    64'(bpt_enable), 64'h0);

        // Reset in the middle of a sweep
        tick();
        clear_req = 1'b1;
        #1;
        tick();
        clear_req = 1'b0;
        #1;
        check("rs_drain_busy", 64'(busy), 64'h1);
        for (int i = 0; i <= 500; i++) tick();
        check("rs_idx500", 64'(bpt_pc), 64'h7D0);
        nRST = 1'b0;
        #1;
        $display("reset asserted mid-sweep");
        check("rs_en",    64'(bpt_enable), 64'h0);
        check("rs_pc",    64'(bpt_pc),     64'h0);
        check("rs_clr",   64'(bpt_clear),  64'h0);
        check("rs_busy",  64'(busy),       64'h0);
        check("rs_ready", 64'(res_ready),  64'h3);
        tick();
        nRST = 1'b1;
        tick();
        res_valid = 2'b10; res_pc = {32'h5550, 32'h0}; res_taken = 2'b10;
        #1;
        check("rs_acc_ready", 64'(res_ready), 64'h3);
        tick();
        res_valid = 2'b00;
        #1;
        check("rs_acc_en", 64'(bpt_enable), 64'h1);
        check("rs_acc_pc", 64'(bpt_pc),     64'h5550);
        tick();

`ifdef BPT_UPDATE_STATS_EN
        // Ten updates, three of them mispredicted, then a sweep that must not count
        nRST = 1'b0;
        #1;
        check("st_rst_upd", 64'(stat_updates), 64'h0);
        tick();
        nRST = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            res_valid        = (k < 10) ? 2'b01 : 2'b00;
            res_pc           = {32'h0, 32'h6000 + 32'(4 * k)};
            bpt_pred_correct = !(k == 3 || k == 5 || k == 8);
            #1;
        end
        tick();
        bpt_pred_correct = 1'b1;
        #1;
        $display("stats updates=%0d mispredicts=%0d", stat_updates, stat_mispredicts);
        check("st_upd",  64'(stat_updates),     64'd10);
        check("st_misp", 64'(stat_mispredicts), 64'd3);
        tick();
        clear_req = 1'b1;
        bpt_pred_correct = 1'b0;
        #1;
        seen = 1'b0;
        for (int n = 0; n < 2100 && !seen; n++) begin
            tick();
            clear_req = 1'b0;
            #1;
            if (sweep_done) seen = 1'b1;
        end
        check("st_sweep_seen", 64'(seen), 64'h1);
        tick();
        check("st_upd_after",  64'(stat_updates),     64'd10);
        check("st_misp_after", 64'(stat_mispredicts), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
